// File: rtl/uart_word_rx_fsm_pkg.sv
// ============================================================================
// Module  : uart_word_rx_fsm_pkg
// Brief   : Shared types and constants for the UART word receiver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_word_rx_fsm_pkg;

   typedef enum logic [1:0] {
      IDLE_R = 2'd0,
      RECV_R = 2'd1,
      DONE_R = 2'd2
   } word_rx_state_t;

   localparam int UART_BYTE_W = 8;

endpackage

`default_nettype wire

// File: rtl/uart_word_rx_fsm_timeout_cnt.sv
// ============================================================================
// Module  : uart_rx_timeout_cnt
// Brief   : Clear/enable up-counter with a terminal-count flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_timeout_cnt #(
   parameter int WIDTH    = 17,
   parameter int TERMINAL = 99999
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_count <= '0;
      end else if (en) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign tc = (r_count == WIDTH'(TERMINAL));

endmodule

`default_nettype wire

// File: rtl/uart_word_rx_fsm.sv
// ============================================================================
// Module  : uart_word_rx_fsm
// Brief   : Assembles consecutive UART bytes into words with a valid/ready
//           output buffer, discarding partial words on timeout/framing error.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_word_rx_fsm
   import uart_word_rx_fsm_pkg::*;
#(
   parameter int BYTES_PER_WORD = 4,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int MSB_FIRST      = 0
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    rx_byte_valid,
   input  logic [7:0]                              rx_byte,
   input  logic                                    rx_frame_err,
   input  logic                                    word_ready,
   output logic [8*BYTES_PER_WORD-1:0]             word_data,
   output logic                                    word_valid,
   output logic [$clog2(BYTES_PER_WORD+1)-1:0]     byte_count,
   output logic                                    timeout_err,
   output logic                                    overrun_err,
   output logic                                    frame_err,
   output logic [1:0]                              state_out
);

   localparam int c_BC_W   = $clog2(BYTES_PER_WORD + 1);
   localparam int c_WORD_W = UART_BYTE_W * BYTES_PER_WORD;
   localparam int c_TMR_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [c_BC_W-1:0] c_LAST_IDX = c_BC_W'(BYTES_PER_WORD - 1);

   word_rx_state_t            r_state, w_state_next;
   logic [c_BC_W-1:0]         r_byte_count, w_byte_count_next;
   logic [c_WORD_W-1:0]       r_asm, w_asm_next;
   logic [c_WORD_W-1:0]       r_word_data;
   logic                      r_word_valid;
   logic                      r_timeout_err, r_overrun_err, r_frame_err;
   logic                      w_store, w_first, w_timeout, w_transfer;
   logic                      w_tmr_clr, w_tmr_en, w_tmr_tc;
   logic [c_BC_W-1:0]         w_wr_idx;
   logic [BYTES_PER_WORD-1:0] w_slot_hit;

   // Logical byte index being written; zero whenever a new word starts.
   assign w_wr_idx = (r_state == RECV_R) ? r_byte_count : '0;

   // Map each physical byte lane to the logical slot that lands in it.
   for (genvar k = 0; k < BYTES_PER_WORD; k++) begin : g_slot
      localparam int c_POS = (MSB_FIRST != 0) ? (BYTES_PER_WORD - 1 - k) : k;
      assign w_slot_hit[k] = (w_wr_idx == c_BC_W'(c_POS));
   end

   always_comb begin
      w_state_next      = r_state;
      w_byte_count_next = r_byte_count;
      w_asm_next        = r_asm;
      w_store           = 1'b0;
      w_first           = 1'b0;
      w_timeout         = 1'b0;
      w_transfer        = (r_state == DONE_R);

      if (rx_frame_err) begin
         w_state_next      = IDLE_R;
         w_byte_count_next = '0;
      end else begin
         case (r_state)
            IDLE_R, DONE_R: begin
               w_state_next = IDLE_R;
               if (rx_byte_valid) begin
                  w_store           = 1'b1;
                  w_first           = 1'b1;
                  w_byte_count_next = c_BC_W'(1);
                  w_state_next      = RECV_R;
               end
            end
            RECV_R: begin
               if (rx_byte_valid) begin
                  w_store = 1'b1;
                  if (r_byte_count == c_LAST_IDX) begin
                     w_state_next      = DONE_R;
                     w_byte_count_next = '0;
                  end else begin
                     w_byte_count_next = r_byte_count + c_BC_W'(1);
                  end
               end else if (w_tmr_tc) begin
                  w_timeout         = 1'b1;
                  w_byte_count_next = '0;
                  w_state_next      = IDLE_R;
               end
            end
            default: begin
               w_state_next      = IDLE_R;
               w_byte_count_next = '0;
            end
         endcase
      end

      // A new word clears the lanes so no bytes of an older word survive.
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
         if (w_store && w_slot_hit[k]) begin
            w_asm_next[k*UART_BYTE_W +: UART_BYTE_W] = rx_byte;
         end else if (w_first) begin
            w_asm_next[k*UART_BYTE_W +: UART_BYTE_W] = '0;
         end
      end
   end

   assign w_tmr_en  = (r_state == RECV_R);
   assign w_tmr_clr = rx_byte_valid | rx_frame_err | (r_state != RECV_R) | w_timeout;

   uart_rx_timeout_cnt #(
      .WIDTH    (c_TMR_W),
      .TERMINAL (TIMEOUT_CYCLES - 1)
   ) u_timeout_cnt (
      .clk (clk),
      .rst (rst),
      .clr (w_tmr_clr),
      .en  (w_tmr_en),
      .tc  (w_tmr_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE_R;
         r_byte_count  <= '0;
         r_asm         <= '0;
         r_timeout_err <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_byte_count  <= w_byte_count_next;
         r_asm         <= w_asm_next;
         r_timeout_err <= w_timeout;
         r_frame_err   <= rx_frame_err;
      end
   end

   // Single-entry output buffer; a full, unaccepted buffer drops the new word.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_word_data   <= '0;
         r_word_valid  <= 1'b0;
         r_overrun_err <= 1'b0;
      end else begin
         r_overrun_err <= 1'b0;
         if (w_transfer) begin
            if (!r_word_valid || word_ready) begin
               r_word_data  <= r_asm;
               r_word_valid <= 1'b1;
            end else begin
               r_overrun_err <= 1'b1;
            end
         end else if (word_ready) begin
            r_word_valid <= 1'b0;
         end
      end
   end

   assign word_data   = r_word_data;
   assign word_valid  = r_word_valid;
   assign byte_count  = r_byte_count;
   assign timeout_err = r_timeout_err;
   assign overrun_err = r_overrun_err;
   assign frame_err   = r_frame_err;
   assign state_out   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_uart_word_rx_fsm.sv
// ============================================================================
// Module  : tb_uart_word_rx_fsm
// Brief   : Directed self-checking bench for uart_word_rx_fsm (LSB/MSB-first).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_word_rx_fsm;

   localparam int c_TO = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_byte_valid;
   logic [7:0]  rx_byte;
   logic        rx_frame_err;
   logic        word_ready;

   logic [31:0] lsb_data, msb_data;
   logic        lsb_valid, msb_valid;
   logic [2:0]  lsb_bc, msb_bc;
   logic        lsb_to, msb_to, lsb_ov, msb_ov, lsb_fe, msb_fe;
   logic [1:0]  lsb_state, msb_state;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_word_rx_fsm #(.BYTES_PER_WORD(4), .TIMEOUT_CYCLES(c_TO), .MSB_FIRST(0)) dut_lsb (
      .clk(clk), .rst(rst), .rx_byte_valid(rx_byte_valid), .rx_byte(rx_byte),
      .rx_frame_err(rx_frame_err), .word_ready(word_ready), .word_data(lsb_data),
      .word_valid(lsb_valid), .byte_count(lsb_bc), .timeout_err(lsb_to),
      .overrun_err(lsb_ov), .frame_err(lsb_fe), .state_out(lsb_state));

   uart_word_rx_fsm #(.BYTES_PER_WORD(4), .TIMEOUT_CYCLES(c_TO), .MSB_FIRST(1)) dut_msb (
      .clk(clk), .rst(rst), .rx_byte_valid(rx_byte_valid), .rx_byte(rx_byte),
      .rx_frame_err(rx_frame_err), .word_ready(word_ready), .word_data(msb_data),
      .word_valid(msb_valid), .byte_count(msb_bc), .timeout_err(msb_to),
      .overrun_err(msb_ov), .frame_err(msb_fe), .state_out(msb_state));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_byte_valid = 1'b1;
      rx_byte       = b;
      tick();
      rx_byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   initial begin
      int found;
      logic msb_seen;
      rst = 1'b1; rx_byte_valid = 1'b0; rx_byte = '0; rx_frame_err = 1'b0; word_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_valid", {31'd0, lsb_valid}, 32'd0);
      chk("rst_data",  lsb_data, 32'd0);
      chk("rst_bc",    {29'd0, lsb_bc}, 32'd0);
      chk("rst_state", {30'd0, lsb_state}, 32'd0);

      // 1/2: 10-cycle spacing, both byte orders
      word_ready = 1'b1;
      send_byte(8'h11); repeat (9) tick();
      send_byte(8'h22); repeat (9) tick();
      send_byte(8'h33); repeat (9) tick();
      send_byte(8'h44);
      chk("t1_done_state", {30'd0, lsb_state}, 32'd2);
      chk("t1_done_bc",    {29'd0, lsb_bc}, 32'd0);
      chk("t1_valid_early", {31'd0, lsb_valid}, 32'd0);
      tick();
      chk("t1_valid", {31'd0, lsb_valid}, 32'd1);
      chk("t1_data_lsb", lsb_data, 32'h44332211);
      chk("t2_valid_msb", {31'd0, msb_valid}, 32'd1);
      chk("t2_data_msb", msb_data, 32'h11223344);
      tick();
      chk("t1_valid_drop", {31'd0, lsb_valid}, 32'd0);
      repeat (2) tick();

      // 3: timeout discards partial word
      send_byte(8'hAA);
      send_byte(8'hBB);
      chk("t3_bc2", {29'd0, lsb_bc}, 32'd2);
      found = 0; msb_seen = 1'b0;
      for (int i = 1; i <= 2*c_TO; i++) begin
         tick();
         if (lsb_to) begin
            found = i;
            msb_seen = msb_to;
            break;
         end
      end
      chk("t3_to_lat", found, c_TO);
      chk("t3_to_msb", {31'd0, msb_seen}, 32'd1);
      chk("t3_to_bc", {29'd0, lsb_bc}, 32'd0);
      chk("t3_to_state", {30'd0, lsb_state}, 32'd0);
      tick();
      chk("t3_to_pulse", {31'd0, lsb_to}, 32'd0);
      send_word(32'h04030201);
      tick();
      chk("t3_data_lsb", lsb_data, 32'h04030201);
      chk("t3_data_msb", msb_data, 32'h01020304);
      repeat (2) tick();

      // 4: overrun with consumer stalled
      word_ready = 1'b0;
      send_word(32'hA4A3A2A1);
      tick();
      chk("t4_valid", {31'd0, lsb_valid}, 32'd1);
      chk("t4_data1", lsb_data, 32'hA4A3A2A1);
      send_word(32'hB4B3B2B1);
      chk("t4_ov_early", {31'd0, lsb_ov}, 32'd0);
      tick();
      chk("t4_ov", {31'd0, lsb_ov}, 32'd1);
      chk("t4_ov_msb", {31'd0, msb_ov}, 32'd1);
      chk("t4_held", lsb_data, 32'hA4A3A2A1);
      tick();
      chk("t4_ov_pulse", {31'd0, lsb_ov}, 32'd0);
      chk("t4_still_valid", {31'd0, lsb_valid}, 32'd1);
      word_ready = 1'b1;
      tick();
      chk("t4_drop", {31'd0, lsb_valid}, 32'd0);
      repeat (2) tick();

      // 5: framing error, including a byte coincident with the error
      send_byte(8'h55);
      rx_frame_err = 1'b1;
      tick();
      rx_frame_err = 1'b0;
      chk("t5_fe", {31'd0, lsb_fe}, 32'd1);
      chk("t5_fe_msb", {31'd0, msb_fe}, 32'd1);
      chk("t5_bc", {29'd0, lsb_bc}, 32'd0);
      tick();
      chk("t5_fe_pulse", {31'd0, lsb_fe}, 32'd0);
      rx_byte_valid = 1'b1; rx_byte = 8'h66; rx_frame_err = 1'b1;
      tick();
      rx_byte_valid = 1'b0; rx_frame_err = 1'b0;
      chk("t5_fe_byte_bc", {29'd0, lsb_bc}, 32'd0);
      chk("t5_fe_byte_state", {30'd0, lsb_state}, 32'd0);
      send_word(32'hC4C3C2C1);
      tick();
      chk("t5_valid", {31'd0, lsb_valid}, 32'd1);
      chk("t5_data", lsb_data, 32'hC4C3C2C1);
      repeat (2) tick();

      // 6: reset mid-word with a word held
      word_ready = 1'b0;
      send_word(32'hD4D3D2D1);
      tick();
      send_byte(8'hE1); send_byte(8'hE2); send_byte(8'hE3);
      chk("t6_pre_bc", {29'd0, lsb_bc}, 32'd3);
      chk("t6_pre_valid", {31'd0, lsb_valid}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_valid", {31'd0, lsb_valid}, 32'd0);
      chk("t6_data", lsb_data, 32'd0);
      chk("t6_bc", {29'd0, lsb_bc}, 32'd0);
      chk("t6_state", {30'd0, lsb_state}, 32'd0);
      chk("t6_msb_bc", {29'd0, msb_bc}, 32'd0);
      chk("t6_msb_state", {30'd0, msb_state}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
